draw_rect_ctl: RTL and testbench

DRAW_RECT_CTL -- requirements
Module: draw_rect_ctl

---
 rtl/vga_pkg.sv | 16 +
 rtl/edge_det.sv | 19 +
 rtl/draw_rect_ctl.sv | 120 ++++++++++++
 tb/tb_draw_rect_ctl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA geometry and the bouncing-image controller state type.
package vga_pkg;

  localparam int HOR_PIXELS = 800;
  localparam int VER_PIXELS = 600;
  localparam int RECT_W     = 48;
  localparam int RECT_H     = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FALL = 2'd1,
    RISE = 2'd2,
    STOP = 2'd3
  } ctl_state_t;

endpackage

// File: rtl/edge_det.sv
// Rising-edge detector: registers d and flags the cycle where it goes 0 -> 1.
module edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic d_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= 1'b0;
    else        d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/draw_rect_ctl.sv
// Image position controller: follows the mouse, then on click drops the image
// under per-frame gravity, bounces it off the floor and lets it settle.
module draw_rect_ctl
  import vga_pkg::*;
#(
  parameter int FLOOR_Y = VER_PIXELS - RECT_H,
  parameter int XMAX    = HOR_PIXELS - RECT_W,
  parameter int GRAV    = 1,
  parameter int VMIN    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vblnk,
  input  logic        mouse_left,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        busy
);

  localparam logic [11:0] FLOOR_C = 12'(FLOOR_Y);
  localparam logic [11:0] XMAX_C  = 12'(XMAX);
  localparam logic [11:0] GRAV_C  = 12'(GRAV);
  localparam logic [11:0] VMIN_C  = 12'(VMIN);

  ctl_state_t  state, state_nxt;
  logic [11:0] vel, vel_nxt;
  logic [11:0] xpos_nxt, ypos_nxt;
  logic        busy_nxt;
  logic        tick, click;
  logic [12:0] sum, vel_inc;
  logic [11:0] damped;

  edge_det u_tick_det  (.clk(clk), .rst_n(rst_n), .d(vblnk),      .rise(tick));
  edge_det u_click_det (.clk(clk), .rst_n(rst_n), .d(mouse_left), .rise(click));

  // Widened so a fall step or velocity increment can never wrap.
  assign sum     = {1'b0, ypos} + {1'b0, vel};
  assign vel_inc = {1'b0, vel} + {1'b0, GRAV_C};
  assign damped  = vel - (vel >> 2);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    vel_nxt   = vel;
    xpos_nxt  = xpos;
    ypos_nxt  = ypos;

    unique case (state)
      IDLE: begin
        if (click) begin
          state_nxt = FALL;
          vel_nxt   = '0;
        end else begin
          xpos_nxt = (mouse_xpos > XMAX_C)  ? XMAX_C  : mouse_xpos;
          ypos_nxt = (mouse_ypos > FLOOR_C) ? FLOOR_C : mouse_ypos;
        end
      end

      FALL: begin
        if (tick) begin
          if (sum >= {1'b0, FLOOR_C}) begin
            ypos_nxt = FLOOR_C;
            if (damped < VMIN_C) begin
              state_nxt = STOP;
              vel_nxt   = '0;
            end else begin
              state_nxt = RISE;
              vel_nxt   = damped;
            end
          end else begin
            ypos_nxt = sum[11:0];
            vel_nxt  = vel_inc[12] ? 12'hFFF : vel_inc[11:0];
          end
        end
      end

      RISE: begin
        if (tick) begin
          if (vel <= GRAV_C || vel >= ypos) begin
            ypos_nxt  = (vel >= ypos) ? 12'd0 : ypos - vel;
            vel_nxt   = '0;
            state_nxt = FALL;
          end else begin
            // vel > GRAV and vel < ypos here, so neither subtraction underflows.
            ypos_nxt = ypos - vel;
            vel_nxt  = vel - GRAV_C;
          end
        end
      end

      STOP: begin
        ypos_nxt = FLOOR_C;
        if (click) state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt == FALL) || (state_nxt == RISE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      vel   <= '0;
      xpos  <= '0;
      ypos  <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      vel   <= vel_nxt;
      xpos  <= xpos_nxt;
      ypos  <= ypos_nxt;
      busy  <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_draw_rect_ctl.sv
// Directed self-checking bench for draw_rect_ctl: follow/clamp, fall, bounce,
// settle, ignored/simultaneous events and asynchronous reset.
module tb_draw_rect_ctl;
  import vga_pkg::*;

  localparam int FLOOR_Y = 536;
  localparam int XMAX    = 752;
  localparam int GRAV    = 1;
  // With VMIN=2 the integer damping locks into a steady 3 px/frame bounce
  // (3 - 3/4 = 3), so VMIN=4 is used to let the motion decay to STOP.
  localparam int VMIN    = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vblnk = 1'b0;
  logic        mouse_left = 1'b0;
  logic [11:0] mouse_xpos = '0;
  logic [11:0] mouse_ypos = '0;
  logic [11:0] xpos, ypos;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model of the motion, advanced once per frame tick.
  int m_y, m_v, m_st;

  draw_rect_ctl #(.FLOOR_Y(FLOOR_Y), .XMAX(XMAX), .GRAV(GRAV), .VMIN(VMIN)) dut (
    .clk(clk), .rst_n(rst_n), .vblnk(vblnk), .mouse_left(mouse_left),
    .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos),
    .xpos(xpos), .ypos(ypos), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_tick();
    vblnk = 1'b1;
    step();
    vblnk = 1'b0;
    step();
  endtask

  task automatic click();
    mouse_left = 1'b1;
    step();
    mouse_left = 1'b0;
    step();
  endtask

  task automatic model_tick();
    if (m_st == int'(FALL)) begin
      if (m_y + m_v >= FLOOR_Y) begin
        int d;
        d   = m_v - m_v / 4;
        m_y = FLOOR_Y;
        if (d < VMIN) begin m_st = int'(STOP); m_v = 0; end
        else          begin m_st = int'(RISE); m_v = d; end
      end else begin
        m_y = m_y + m_v;
        m_v = m_v + GRAV;
      end
    end else if (m_st == int'(RISE)) begin
      if (m_v <= GRAV || m_v >= m_y) begin
        m_y  = (m_v >= m_y) ? 0 : m_y - m_v;
        m_v  = 0;
        m_st = int'(FALL);
      end else begin
        m_y = m_y - m_v;
        m_v = m_v - GRAV;
      end
    end
  endtask

  initial begin
    int mism, under, n;

    // Reset state
    #3;
    check("reset_xpos", int'(xpos), 0);
    check("reset_ypos", int'(ypos), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_state", int'(dut.state), int'(IDLE));

    // Follow and clamp
    mouse_xpos = 12'd100; mouse_ypos = 12'd200;
    @(posedge clk); #1; rst_n = 1'b1;
    step();
    check("follow_x", int'(xpos), 100);
    check("follow_y", int'(ypos), 200);
    mouse_xpos = 12'd900; mouse_ypos = 12'd700;
    step();
    check("clamp_x", int'(xpos), XMAX);
    check("clamp_y", int'(ypos), FLOOR_Y);

    // Free fall from the top
    mouse_xpos = 12'd300; mouse_ypos = 12'd0;
    step();
    check("top_y", int'(ypos), 0);
    click();
    check("fall_state", int'(dut.state), int'(FALL));
    check("fall_vel0", int'(dut.vel), 0);
    mouse_xpos = 12'd10; mouse_ypos = 12'd20;
    repeat (33) frame_tick();
    check("fall33_y", int'(ypos), 528);
    check("fall33_vel", int'(dut.vel), 33);
    check("fall33_busy", int'(busy), 1);
    frame_tick();
    check("bounce_y", int'(ypos), FLOOR_Y);
    check("bounce_vel", int'(dut.vel), 25);
    check("bounce_state", int'(dut.state), int'(RISE));

    // Rise to apex, cross-checked against the model
    m_y = FLOOR_Y; m_v = 25; m_st = int'(RISE);
    repeat (24) begin frame_tick(); model_tick(); end
    check("rise24_vel", int'(dut.vel), 1);
    check("rise24_y_model", int'(ypos), m_y);
    frame_tick(); model_tick();
    check("apex_y", int'(ypos), 211);
    check("apex_y_model", int'(ypos), m_y);
    check("apex_state", int'(dut.state), int'(FALL));
    check("apex_vel", int'(dut.vel), 0);

    // Click during FALL is ignored
    click();
    check("fall_click_state", int'(dut.state), int'(FALL));
    check("fall_click_y", int'(ypos), 211);

    // Settle to STOP, tracking the model every frame
    mism = 0; under = 0; n = 0;
    while (m_st != int'(STOP) && n < 2000) begin
      frame_tick(); model_tick(); n++;
      if (int'(ypos) != m_y || int'(dut.vel) != m_v || int'(dut.state) != m_st) mism++;
      if (int'(ypos) > FLOOR_Y) under++;
    end
    check("settle_track", mism, 0);
    check("settle_no_wrap", under, 0);
    check("settle_state", int'(dut.state), int'(STOP));
    check("settle_y", int'(ypos), FLOOR_Y);
    check("settle_busy", int'(busy), 0);
    check("settle_xpos_held", int'(xpos), 300);

    // Click in STOP returns to IDLE and tracking resumes
    mouse_xpos = 12'd40; mouse_ypos = 12'd50;
    click();
    check("resume_state", int'(dut.state), int'(IDLE));
    check("resume_x", int'(xpos), 40);
    check("resume_y", int'(ypos), 50);

    // Click and tick together in IDLE: fall starts, position frozen
    mouse_xpos = 12'd60; mouse_ypos = 12'd70;
    mouse_left = 1'b1; vblnk = 1'b1;
    step();
    mouse_left = 1'b0; vblnk = 1'b0;
    check("simul_state", int'(dut.state), int'(FALL));
    check("simul_y", int'(ypos), 50);
    check("simul_x", int'(xpos), 40);
    step();
    check("simul_hold_y", int'(ypos), 50);

    // Reset in the middle of a rise
    n = 0;
    while (dut.state != RISE && n < 100) begin frame_tick(); n++; end
    check("reach_rise", int'(dut.state), int'(RISE));
    frame_tick();
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_x", int'(xpos), 0);
    check("async_rst_y", int'(ypos), 0);
    check("async_rst_state", int'(dut.state), int'(IDLE));
    check("async_rst_busy", int'(busy), 0);
    #2;
    rst_n = 1'b1;
    step();
    check("post_rst_x", int'(xpos), 60);
    check("post_rst_y", int'(ypos), 70);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
